// File: rtl/nonce_result_collector.sv
// -----------------------------------------------------------------------------
// nonce_result_collector
//
// Sits behind final_hash_validator. Rebuilds the absolute nonce of each
// result from a per-block index counter offset by NONCE_BASE, and buffers
// winning nonces (tagged with a block sequence number) in a first-word
// fall-through FIFO that the host reader drains with a valid/ready handshake.
//
// Optional build macro: NONCE_COLLECTOR_STATS_EN adds the hash_count and
// win_count statistics outputs.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   valid_i      result present this cycle
//   newblock_i   with valid_i: first result of a new block
//   success_i    with valid_i: hash met difficulty
//   res_valid    FIFO head valid
//   res_ready    reader accepts head
//   res_nonce    nonce of head entry (0 when empty)
//   res_tag      block tag of head entry (0 when empty)
//   overflow     sticky: a win was dropped because the FIFO was full
//   exhausted    current block has delivered all 2^NONCEBITS results
//   clr_overflow synchronous clear of overflow (a coincident drop wins)
//   hash_count   (stats) accepted results since reset, saturating
//   win_count    (stats) push attempts since reset, saturating
// -----------------------------------------------------------------------------
module nonce_result_collector #(
  parameter logic [31:0] NONCE_BASE = 32'h42a14600,
  parameter int          NONCEBITS  = 6,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TAGBITS    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               newblock_i,
  input  logic               success_i,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_nonce,
  output logic [TAGBITS-1:0] res_tag,
  output logic               overflow,
  output logic               exhausted,
`ifdef NONCE_COLLECTOR_STATS_EN
  output logic [31:0]        hash_count,
  output logic [15:0]        win_count,
`endif
  input  logic               clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TAGBITS + 32;

  localparam logic [NONCEBITS-1:0] IDX_ZERO = {NONCEBITS{1'b0}};
  localparam logic [NONCEBITS-1:0] IDX_ONE  = {{(NONCEBITS-1){1'b0}}, 1'b1};
  localparam logic [NONCEBITS-1:0] IDX_LAST = {NONCEBITS{1'b1}};
  localparam logic [TAGBITS-1:0]   TAG_ONE  = {{(TAGBITS-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]        PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]          CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]          CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]          CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    EXHAUSTED = 2'd2
  } state_t;

  state_t                state_r;
  logic [NONCEBITS-1:0]  counter_r;
  logic [TAGBITS-1:0]    tag_r;
  logic                  exhausted_r;

  logic                  accept_s;
  logic                  push_s;
  logic [NONCEBITS-1:0]  index_s;
  logic [TAGBITS-1:0]    tag_use_s;
  logic [31:0]           nonce_s;
  logic [EW-1:0]         entry_s;

  logic [EW-1:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW:0]           count_r;
  logic                  res_valid_r;
  logic [EW-1:0]         head_r;
  logic                  overflow_r;

  logic                  pop_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  drop_s;
  logic [AW:0]           count_nx_s;
  logic [AW:0]           remain_s;
  logic [AW-1:0]         rd_nx_s;
  logic [EW-1:0]         head_nx_s;

  // Decide whether this cycle's result belongs to a block and build its entry.
  always_comb begin
    accept_s  = 1'b0;
    index_s   = IDX_ZERO;
    tag_use_s = tag_r;
    if (valid_i && newblock_i) begin
      // A new block always restarts at index 0 with the next tag.
      accept_s  = 1'b1;
      index_s   = IDX_ZERO;
      tag_use_s = tag_r + TAG_ONE;
    end else if (valid_i && (state_r == RUN)) begin
      accept_s  = 1'b1;
      index_s   = counter_r;
      tag_use_s = tag_r;
    end else begin
      // No block context (IDLE/EXHAUSTED) or no result: nothing consumed.
      accept_s  = 1'b0;
      index_s   = IDX_ZERO;
      tag_use_s = tag_r;
    end
    push_s  = accept_s & success_i;
    nonce_s = NONCE_BASE + {{(32-NONCEBITS){1'b0}}, index_s};
    entry_s = {tag_use_s, nonce_s};
  end

  // Block-tracking FSM: nonce index counter, block tag and exhaustion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      counter_r   <= IDX_ZERO;
      tag_r       <= {TAGBITS{1'b0}};
      exhausted_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, EXHAUSTED: begin
          if (valid_i && newblock_i) begin
            state_r     <= RUN;
            counter_r   <= IDX_ONE;
            tag_r       <= tag_use_s;
            exhausted_r <= 1'b0;
          end
        end
        RUN: begin
          if (valid_i && newblock_i) begin
            counter_r <= IDX_ONE;
            tag_r     <= tag_use_s;
          end else if (valid_i) begin
            counter_r <= counter_r + IDX_ONE;
            // Consuming the last index ends the block's nonce space.
            if (counter_r == IDX_LAST) begin
              state_r     <= EXHAUSTED;
              exhausted_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          counter_r   <= IDX_ZERO;
          exhausted_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: push/pop arbitration and next-state head selection.
  always_comb begin
    pop_s   = (count_r != CNT_ZERO) & res_ready;
    full_s  = (count_r == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    wr_en_s = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;

    case ({wr_en_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase

    if (pop_s) begin
      rd_nx_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_nx_s = rd_ptr_r;
    end

    // Entries that survive this cycle, not counting the incoming push.
    remain_s = count_r - {{AW{1'b0}}, pop_s};

    if (count_nx_s == CNT_ZERO) begin
      head_nx_s = {EW{1'b0}};
    end else if (remain_s == CNT_ZERO) begin
      // Only the entry being written now is left: bypass it to the head.
      head_nx_s = entry_s;
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // FIFO storage, pointers, registered head and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= CNT_ZERO;
      res_valid_r <= 1'b0;
      head_r      <= {EW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_nx_s;
      count_r     <= count_nx_s;
      res_valid_r <= (count_nx_s != CNT_ZERO);
      head_r      <= head_nx_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_nonce = head_r[31:0];
  assign res_tag   = head_r[EW-1:32];
  assign overflow  = overflow_r;
  assign exhausted = exhausted_r;

`ifdef NONCE_COLLECTOR_STATS_EN
  logic [31:0] hash_count_r;
  logic [15:0] win_count_r;

  // Saturating counters of accepted results and attempted pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_count_r <= 32'd0;
      win_count_r  <= 16'd0;
    end else begin
      if (accept_s && (hash_count_r != 32'hFFFF_FFFF)) begin
        hash_count_r <= hash_count_r + 32'd1;
      end
      if (push_s && (win_count_r != 16'hFFFF)) begin
        win_count_r <= win_count_r + 16'd1;
      end
    end
  end

  assign hash_count = hash_count_r;
  assign win_count  = win_count_r;
`endif

endmodule

// File: doc/nonce_result_collector.md
Name: nonce_result_collector

Overview:
- Sits directly downstream of final_hash_validator inside bcminer.
- Consumes the per-cycle valid/newblock/success stream and reconstructs the absolute nonce of each result from a per-block counter offset by NONCE_BASE.
- Buffers winning nonces, tagged with a block sequence number, in a FIFO that the host-side reader drains over a valid/ready handshake.
- Tracks dropped wins and per-block nonce-space exhaustion.

Parameters:
- NONCE_BASE, 32'h42a14600: nonce value of the first result of each block; matches the sha core PROCESSORINDEX.
- NONCEBITS, 6: width of the per-block result counter; 2^NONCEBITS results per block; aligns with block_storage LOGNCYCLES.
- FIFO_DEPTH, 4: number of result entries; power of two, ≥2.
- TAGBITS, 4: width of the block sequence tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_i  in  1  result present this cycle (from hval valid_o)
- newblock_i  in  1  with valid_i: first result of a new block (from hval newblock_o)
- success_i  in  1  with valid_i: hash met difficulty
- res_valid  out  1  FIFO head valid
- res_ready  in  1  reader accepts head
- res_nonce  out  32  nonce of head entry
- res_tag  out  TAGBITS  block tag of head entry
- overflow  out  1  sticky: a win was dropped because the FIFO was full
- exhausted  out  1  current block has delivered all 2^NONCEBITS results
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - res_valid=0, overflow=0, exhausted=0.
  - FIFO empty, counter=0, tag=0, FSM=IDLE.
  - res_nonce and res_tag read 0 when the FIFO is empty.
- Inputs other than valid_i are ignored when valid_i=0.
- FSM states: IDLE, RUN, EXHAUSTED.
  - IDLE: valid_i without newblock_i is ignored (no block context). valid_i&newblock_i → RUN.
  - RUN: each valid_i consumes one nonce index. When the index consumed equals 2^NONCEBITS-1 → EXHAUSTED.
  - EXHAUSTED: exhausted=1. valid_i without newblock_i is ignored. valid_i&newblock_i → RUN.
- Nonce index rules:
  - valid_i&newblock_i: result uses index 0; counter becomes 1; tag increments (mod 2^TAGBITS); exhausted clears.
  - Tag value used for that result is the post-increment value. The first block after reset gets tag 1.
  - valid_i in RUN without newblock_i: uses the current counter value, then the counter increments.
  - Nonce = NONCE_BASE + zero-extended index, mod 2^32 (wraps silently).
- Push rule: only when success_i is set on a cycle whose result is accepted per the FSM rules above. Entry = {tag, nonce}.
- FIFO:
  - Registered, first-word fall-through.
  - Push at cycle N → res_valid=1 at cycle N+1 if empty.
  - Pop when res_valid&res_ready.
  - Push while full with a simultaneous pop: push accepted; occupancy unchanged.
  - Push while full without a pop: entry dropped; overflow←1 next cycle.
  - Pop while empty: no effect.
  - Head fields are held stable while res_valid&!res_ready.
- overflow:
  - Cleared by clr_overflow.
  - If clr_overflow coincides with a drop, the set wins.
- Reset mid-operation: all state returns to reset values immediately; buffered entries are lost.

Optional Feature:
- Macro: NONCE_COLLECTOR_STATS_EN.
- With the macro defined, add outputs:
  - hash_count[31:0]: number of accepted results since reset, saturating at 32'hFFFFFFFF.
  - win_count[15:0]: number of pushes attempted since reset, including dropped ones, saturating.
  - Both reset to 0.
- Without the macro: ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then valid_i&newblock_i&success_i at cycle 0 → cycle 1: res_valid=1, res_nonce=32'h42a14600, res_tag=1.
- New block, then 5 non-winning results, then a win → res_nonce=32'h42a14606.
- 64 results in one block, then a 65th valid_i with success_i → exhausted=1 after the 64th; the 65th is not pushed. A following newblock_i clears exhausted and yields tag+1, nonce index 0.
- res_ready=0, 5 wins (depth 4) → 4 entries held, overflow=1. Assert clr_overflow → overflow=0. Drain: 4 entries in push order.
- FIFO full, win with simultaneous pop → no overflow; occupancy stays 4; the new entry appears last.
- Assert rst while the FIFO holds entries and the FSM is in RUN → outputs return to reset values; valid_i without newblock_i is then ignored (IDLE).
